// File: rtl/cic_interpolator.sv
// Multi-stage CIC interpolator: input-rate combs, zero-stuff by RATE, output-rate integrators.
// Define CIC_INTERPOLATOR_UNDERFLOW_FILL_EN to keep stepping with zero samples when the source starves.
module cic_interpolator #(
  parameter int STAGES    = 3,
  parameter int RATE      = 8,
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = IN_WIDTH + (STAGES - 1) * $clog2(RATE)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data
`ifdef CIC_INTERPOLATOR_UNDERFLOW_FILL_EN
  ,
  output logic                 underflow
`endif
);

  localparam int W  = OUT_WIDTH;
  localparam int PW = $clog2(RATE);

  logic [PW-1:0]       phase;
  logic signed [W-1:0] dly   [STAGES];
  logic signed [W-1:0] c     [STAGES+1];
  logic signed [W-1:0] integ [STAGES];
  logic signed [W-1:0] nxt   [STAGES];
  logic signed [W-1:0] u;
  logic                free;
  logic                step;
  logic                load;
  logic                phase_zero;

  assign free       = !out_valid || out_ready;
  assign phase_zero = (phase == '0);

`ifdef CIC_INTERPOLATOR_UNDERFLOW_FILL_EN
  assign step = free;
`else
  assign step = free && (!phase_zero || in_valid);
`endif

  assign in_ready = free && phase_zero && !rst;
  // A phase-0 step loads the combs; without fill this is exactly an accept.
  assign load = step && phase_zero;

  always_comb begin
    c[0] = in_valid ? W'($signed(in_data)) : '0;
    for (int k = 0; k < STAGES; k++) begin
      c[k+1] = c[k] - dly[k];
    end
    u = phase_zero ? c[STAGES] : '0;
    nxt[0] = integ[0] + u;
    for (int k = 1; k < STAGES; k++) begin
      nxt[k] = integ[k] + integ[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      for (int k = 0; k < STAGES; k++) begin
        dly[k]   <= '0;
        integ[k] <= '0;
      end
    end else begin
      if (load) begin
        for (int k = 0; k < STAGES; k++) begin
          dly[k] <= c[k];
        end
      end
      if (step) begin
        for (int k = 0; k < STAGES; k++) begin
          integ[k] <= nxt[k];
        end
        out_data <= nxt[STAGES-1];
        phase    <= (phase == PW'(RATE - 1)) ? '0 : phase + PW'(1);
      end
      if (step) begin
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef CIC_INTERPOLATOR_UNDERFLOW_FILL_EN
  // Sticky: records that a zero sample was substituted at least once since reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      underflow <= 1'b0;
    end else if (load && !in_valid) begin
      underflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_cic_interpolator.sv
// Randomized self-checking bench for cic_interpolator against a polyphase FIR reference
// built from the expanded (1 + z^-1 + ... + z^-(R-1))^N impulse response.
module tb_cic_interpolator;

  localparam int STAGES   = 3;
  localparam int RATE     = 8;
  localparam int IN_WIDTH = 16;
  localparam int W        = IN_WIDTH + (STAGES - 1) * $clog2(RATE);
  localparam int HLEN     = STAGES * (RATE - 1) + 1;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [IN_WIDTH-1:0] in_data = '0;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic [W-1:0]        out_data;
`ifdef CIC_INTERPOLATOR_UNDERFLOW_FILL_EN
  logic                underflow;
`endif

  int     checkCount = 0;
  int     passCount  = 0;
  longint h [HLEN];
  longint xs [$];
  int     outIdx = 0;
  longint outSum = 0;

  cic_interpolator #(
    .STAGES   (STAGES),
    .RATE     (RATE),
    .IN_WIDTH (IN_WIDTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef CIC_INTERPOLATOR_UNDERFLOW_FILL_EN
    ,
    .underflow (underflow)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input longint got, input longint exp);
    checkCount++;
    if (got == exp) passCount++;
    else $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Output k is the zero-stuffed input convolved with h, delayed by STAGES-1 steps.
  function automatic longint modelOut(int k);
    longint acc = 0;
    for (int j = 0; j < HLEN; j++) begin
      int m = k - (STAGES - 1) - j;
      if (m >= 0 && (m % RATE) == 0 && (m / RATE) < xs.size())
        acc += h[j] * xs[m / RATE];
    end
    return acc;
  endfunction

  // Transfers are predicted at the negedge; inputs only change just after posedge.
  always @(negedge clk) begin
    if (rst) begin
      xs.delete();
      outIdx = 0;
      outSum = 0;
    end else begin
`ifdef CIC_INTERPOLATOR_UNDERFLOW_FILL_EN
      if (in_ready) xs.push_back(in_valid ? longint'($signed(in_data)) : 0);
`else
      if (in_valid && in_ready) xs.push_back(longint'($signed(in_data)));
`endif
      if (out_valid && out_ready) begin
        longint full;
        logic signed [W-1:0] trunc;
        longint got;
        full  = modelOut(outIdx);
        trunc = full[W-1:0];
        got   = longint'($signed(out_data));
        checkOutput("out_seq", got, longint'(trunc));
        outSum += got;
        outIdx++;
      end
    end
  end

  // mode: 0 DC 100, 1 impulse, 2 random, 3 extremes, 4 starve, 5 random always-valid
  task automatic applyStimulus(input int mode, input int cycles, input int readyPct);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      out_ready = ($urandom_range(0, 99) < readyPct);
      case (mode)
        0: begin in_valid = 1'b1; in_data = 16'd100; end
        1: begin in_valid = 1'b1; in_data = (xs.size() == 0) ? 16'd1 : 16'd0; end
        2: begin in_valid = ($urandom_range(0, 3) != 0); in_data = 16'($urandom); end
        3: begin in_valid = 1'b1; in_data = (xs.size() % 2 == 0) ? 16'h8000 : 16'h7FFF; end
        4: begin in_valid = 1'b0; in_data = 16'($urandom); end
        default: begin in_valid = 1'b1; in_data = 16'($urandom); end
      endcase
    end
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    longint tmp [HLEN];
    int len;
    int readyCount;
    logic [W-1:0] held;

    for (int i = 0; i < HLEN; i++) h[i] = 0;
    h[0] = 1;
    len = 1;
    for (int s = 0; s < STAGES; s++) begin
      for (int i = 0; i < HLEN; i++) tmp[i] = 0;
      for (int i = 0; i < len; i++)
        for (int j = 0; j < RATE; j++) tmp[i+j] += h[i];
      len += RATE - 1;
      for (int i = 0; i < HLEN; i++) h[i] = tmp[i];
    end

    // Reset with handshakes offered on both sides.
    in_valid = 1'b1;
    out_ready = 1'b1;
    in_data = 16'd55;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("rst_in_ready", longint'(in_ready), 0);
      checkOutput("rst_out_valid", longint'(out_valid), 0);
      checkOutput("rst_out_data", longint'(out_data), 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("first_accept", longint'(in_ready && in_valid), 1);

    // DC: gain RATE^(STAGES-1), one accept per RATE cycles.
    applyStimulus(0, 100, 100);
    readyCount = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (in_ready) readyCount++;
    end
    checkOutput("dc_in_ready_rate", readyCount, 80 / RATE);
    checkOutput("dc_settled", longint'($signed(out_data)), 100 * RATE ** (STAGES - 1));

    // Impulse after a mid-operation reset.
    doReset();
    @(negedge clk);
    checkOutput("midrst_out_valid", longint'(out_valid), 0);
    checkOutput("midrst_out_data", longint'(out_data), 0);
    applyStimulus(1, 60, 100);
    @(negedge clk);
    checkOutput("impulse_sum", outSum, RATE ** STAGES / RATE * RATE);
    checkOutput("impulse_tail", longint'($signed(out_data)), 0);

    // Backpressure mid-frame.
    applyStimulus(5, 21, 100);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    held = out_data;
    checkOutput("bp_valid_start", longint'(out_valid), 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp_hold_data", longint'(out_data), longint'(held));
      checkOutput("bp_hold_valid", longint'(out_valid), 1);
      checkOutput("bp_in_ready", longint'(in_ready), 0);
    end
    applyStimulus(2, 40, 100);

    // Source starvation.
    applyStimulus(5, 13, 100);
    applyStimulus(4, 10, 100);
    @(negedge clk);
`ifdef CIC_INTERPOLATOR_UNDERFLOW_FILL_EN
    checkOutput("starve_out_valid", longint'(out_valid), 1);
    checkOutput("starve_underflow", longint'(underflow), 1);
`else
    checkOutput("starve_out_valid", longint'(out_valid), 0);
    checkOutput("starve_in_ready", longint'(in_ready), 1);
`endif
    applyStimulus(2, 40, 70);

    // Random traffic with random backpressure.
    applyStimulus(2, 300, 70);

    // Full-scale alternating input exercises modular wrap.
    doReset();
    applyStimulus(3, 200, 60);
    applyStimulus(3, 100, 100);

`ifdef CIC_INTERPOLATOR_UNDERFLOW_FILL_EN
    doReset();
    applyStimulus(4, 5, 100);
    @(negedge clk);
    checkOutput("fill_underflow_set", longint'(underflow), 1);
    applyStimulus(5, 20, 100);
    @(negedge clk);
    checkOutput("fill_underflow_sticky", longint'(underflow), 1);
`endif

    @(negedge clk);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/cic_interpolator.md
Name: cic_interpolator

Overview:
- Multi-stage CIC interpolator: comb section at input rate, zero-stuffing upsample by RATE, integrator section at output rate.
- It is the transmit/DAC-side counterpart of the decimating CIC chain. It feeds sigma-delta modulators from low-rate sample sources.
- Valid/ready on both sides. One input sample yields exactly RATE output samples.

Parameters:
- STAGES, 3, number of comb stages and of integrator stages (N); 1..6
- RATE, 8, interpolation factor R; power of two, 2..256
- IN_WIDTH, 16, signed input sample width
- OUT_WIDTH, IN_WIDTH+(STAGES-1)*$clog2(RATE), signed output and internal width W (derived; do not override)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  input sample available
- in_ready  out  1  input sample accepted this cycle when in_valid is also high
- in_data  in  IN_WIDTH  signed input sample
- out_valid  out  1  out_data holds an unconsumed sample
- out_ready  in  1  downstream accepts out_data
- out_data  out  OUT_WIDTH  signed interpolated sample

Behaviour:
- All internal arithmetic is two's complement at width W with modular wrap. in_data is sign-extended to W. The final result is exact because it fits W (Hogenauer); no saturation.
- Reset: phase=0; all comb delay registers, integrators and out_data are 0; out_valid=0; in_ready=0 during rst. Reset mid-operation discards any partial output frame and any pending sample.
- free = !out_valid || out_ready.
- step: free && (phase!=0 || in_valid).
- in_ready = free && phase==0. Accept = in_valid && in_ready, which always coincides with a step at phase 0.
- Comb section (combinational on in_data):
  - c0 = sext(in_data).
  - For each stage k: ck+1 = ck - dk, where dk is that stage's delay register.
  - On accept, dk <= ck.
  - No other update of dk.
- Upsampler value u = cN when phase==0, else 0.
- Integrators update on step only:
  - i0 <= i0 + u.
  - ik <= ik + ik-1 (old value) for k>=1.
  - out_data <= new value of iN-1, i.e. iN-1 + iN-2(old), or i0 + u when STAGES=1.
- Phase counter: on step, phase <= (phase==RATE-1) ? 0 : phase+1.
- out_valid:
  - Set to 1 on step.
  - Cleared when out_valid && out_ready && !step.
  - Holds otherwise.
  - out_data is stable while out_valid && !out_ready.
- Latency: a sample's first contribution reaches out_data on the (STAGES-1)th step after its accept step, with steps counted from 0. out_valid rises 1 cycle after the step.
- Throughput: one output per clock when out_ready is held high and input is always available.
- Underflow: at phase 0 with in_valid=0, no step occurs. The chain freezes and out_valid drops after the pending sample drains.
- Gain: DC x gives steady-state output x·RATE^(STAGES-1).
- Simultaneous rst with any handshake: rst wins and the handshake is ignored.

Optional Feature:
- Macro: CIC_INTERPOLATOR_UNDERFLOW_FILL_EN.
- Defined:
  - At phase 0 with free && !in_valid, a step still occurs with c0 = 0, and the comb delay registers update as for an accepted zero sample.
  - Extra output port underflow (out, 1) is a sticky flag, set in that case and cleared only by rst.
  - The output rate stays constant under source starvation.
- Not defined:
  - The pipeline stalls as described above.
  - The underflow port does not exist.

Test Plan:
- Reset: assert rst 3 cycles with in_valid=1, out_ready=1 -> in_ready=0, out_valid=0, out_data=0 throughout; after release, the first accept happens at phase 0.
- DC (STAGES=3, RATE=8, IN_WIDTH=16): in_data=100 continuously, out_ready=1 -> in_ready pulses once per 8 cycles; output settles to 6400 and stays constant.
- Impulse: one sample 1, then zeros, out_ready=1 -> outputs 0,0,1,3,6,10,15,21,28,36,…; sum over the full response = 512 (R^N / R·R); returns to 0 and stays 0.
- Backpressure: mid-frame drop out_ready for 5 cycles -> out_data and out_valid hold, phase frozen, in_ready=0; resume gives no lost or duplicated samples versus the reference model.
- Underflow (macro off): in_valid low at phase 0 for 10 cycles -> out_valid falls after the pending sample drains and integrators hold; resume matches the model. With the macro on: output continues every cycle, underflow=1 and sticky.
- Extremes: alternating -32768/+32767 inputs -> out_data matches a bit-exact model with no mismatch from wrap.
